prefix_subtractor_pipe: RTL
===========================

Name: prefix_subtractor_pipe

Overview:
Two-stage pipelined two's-complement subtractor. It computes d = a - b as a + ~b + 1 through a parallel-prefix (carry-lookahead) network, and its status flags mirror the carry semantics of the combinational adders.
It uses a valid/ready stream on both sides, so it can sit between operand producers and result consumers in the arithmetic datapath with full backpressure.
Throughput is one operation per cycle. Latency is 2 cycles.

Parameters:
WIDTH, 8, operand and result width; must be a power of two, minimum 4.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair a/b is valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
out_valid  output  1  result fields are valid
out_ready  input  1  consumer accepts the result this cycle
d  output  WIDTH  difference, (a - b) mod 2^WIDTH
borrow  output  1  1 when a < b as unsigned (inverse of carry-out of a + ~b + 1)
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])
zero  output  1  1 when d == 0

Behaviour:
- Reset: synchronous, sampled on the rising clk edge while rst_n == 0, so only one clock and one reset apply.
  - Clears s1_valid, out_valid, d, borrow, ovf and zero to 0.
  - in_ready is 0 while rst_n == 0 and 1 on the first cycle after release.
- Reset mid-operation discards every in-flight operation. No partial result is ever presented.
- Arithmetic:
  - Bit i: p_i = a_i ^ ~b_i, g_i = a_i & ~b_i.
  - The carry-in of 1 is folded into bit 0: G0 = g_0 | p_0.
  - Prefix combine uses (g,p)∘(g',p') = (g | p&g', p&p').
  - Sum bit: d_i = p_i ^ c_{i-1}, with c_{-1} = 1.
  - borrow = ~c_{WIDTH-1}.
- Stage 1 (register S1): on accept, captures
  - p[WIDTH-1:0];
  - the group (G,P) of each aligned 4-bit block, computed by an in-block prefix;
  - the in-block prefix carries assuming a block carry-in of 0 and of 1;
  - a[MSB] and b[MSB].
  - s1_valid is set.
- Stage 2 (output register):
  - Resolves the block carries by a prefix across blocks.
  - Selects the in-block carries per block.
  - Forms d, borrow, ovf and zero, and sets out_valid.
- Timing: no combinational path from a/b to outputs and none from in_valid to out_valid. Only out_ready → in_ready is combinational.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - adv2 = !out_valid || out_ready.
  - S1 moves to the output register when s1_valid && adv2.
  - in_ready = !s1_valid || adv2.
  - Operand accepted at edge N with no stall → out_valid = 1 after edge N+1.
- Stall: while out_valid && !out_ready, d, borrow, ovf and zero are held bit-stable. S1 holds one further operation, and in_ready = 0 once S1 is occupied.
- Bubbles:
  - If S1 is empty and adv2 = 1, out_valid drops after the current result is consumed.
  - Results leave in acceptance order with no drop and no duplication.
- Simultaneous consume and accept: out_ready = 1, out_valid = 1, in_valid = 1 and s1_valid = 1 in the same cycle gives a full-rate shift. The output gets the S1 result, S1 gets the new operands, and nothing is lost.
- in_valid is ignored when in_ready = 0; the producer must hold its operands.
- out_valid may assert without out_ready; the consumer may not force it low.

Test Plan:
- Reset, then a=8'h05, b=8'h03, out_ready=1 → after 2 edges: out_valid=1, d=8'h02, borrow=0, ovf=0, zero=0. in_ready=0 during reset, 1 after.
- a=8'h03, b=8'h05 → d=8'hFE, borrow=1, ovf=0. a=8'h80, b=8'h01 → d=8'h7F, borrow=0, ovf=1. a=8'h7F, b=8'hFF → d=8'h80, borrow=1, ovf=1. a=b=8'hA5 → d=0, zero=1, borrow=0.
- Back-to-back stream of 256 random pairs with out_ready=1 and in_valid=1 every cycle → in_ready stays 1, one result per cycle in order, each matching (a-b)&8'hFF plus the reference flags.
- Hold out_ready=0 for 5 cycles while in_valid=1 → out result held stable, S1 fills, in_ready=0 from the 2nd cycle. On release, both held results drain in order with no loss.
- rst_n=0 for one cycle while both stages are full → next cycle out_valid=0, d=0, in_ready=1. The following accept of a=8'h10, b=8'h01 yields d=8'h0F two cycles later.
- Random in_valid/out_ready toggling, 10k cycles, scoreboard → no drop or duplication, outputs never change while out_valid && !out_ready.

Source files
------------

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage pipelined subtractor d = a + ~b + 1 built on a block-structured prefix carry network.
// Stage 1 resolves carries inside each 4-bit block; stage 2 resolves carries across blocks and forms the flags.
`timescale 1ns/1ps

module prefix_subtractor_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int NB = WIDTH / 4;

    // Handshake
    logic adv2;
    logic accept;
    logic s1_valid_q;
    logic out_valid_q;

    assign adv2     = !out_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || adv2);
    assign accept   = in_valid && in_ready;

    // Stage 1: per-bit propagate plus in-block carries for block carry-in 0 and 1
    logic [WIDTH-1:0] p_d, c0_d, c1_d;
    logic [NB-1:0]    bg_d, bp_d;

    always_comb begin
        logic g_run, p_run, g_bit, p_bit;
        // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
        p_d   = '0;
        c0_d  = '0;
        c1_d  = '0;
        bg_d  = '0;
        bp_d  = '0;
        g_run = 1'b0;
        p_run = 1'b1;
        g_bit = 1'b0;
        p_bit = 1'b0;
        for (int k = 0; k < NB; k++) begin
            g_run = 1'b0;
            p_run = 1'b1;
            for (int j = 0; j < 4; j++) begin
                p_bit = a[4*k+j] ^ ~b[4*k+j];
                g_bit = a[4*k+j] & ~b[4*k+j];
                p_d[4*k+j]  = p_bit;
                g_run       = g_bit | (p_bit & g_run);
                p_run       = p_bit & p_run;
                c0_d[4*k+j] = g_run;
                c1_d[4*k+j] = g_run | p_run;
            end
            bg_d[k] = g_run;
            bp_d[k] = p_run;
        end
    end

    logic [WIDTH-1:0] p_q, c0_q, c1_q;
    logic [NB-1:0]    bg_q, bp_q;
    logic             a_msb_q, b_msb_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
        end else if (adv2) begin
            s1_valid_q <= 1'b0;
        end
    end

    // NOTE: stage-1 payload has no reset; s1_valid_q qualifies it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            p_q     <= p_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            bg_q    <= bg_d;
            bp_q    <= bp_d;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end
    end

    // Stage 2: the global carry-in of 1 enters as block 0's carry-in
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] d_d;
    logic             borrow_d, ovf_d, zero_d;

    always_comb begin
        logic cin;
        carry = '0;
        cin   = 1'b1;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 4; j++) begin
                carry[4*k+j] = cin ? c1_q[4*k+j] : c0_q[4*k+j];
            end
            cin = bg_q[k] | (bp_q[k] & cin);
        end
        d_d      = p_q ^ {carry[WIDTH-2:0], 1'b1};
        borrow_d = ~carry[WIDTH-1];
        ovf_d    = (a_msb_q != b_msb_q) && (d_d[WIDTH-1] != a_msb_q);
        zero_d   = (d_d == '0);
    end

    logic [WIDTH-1:0] d_q;
    logic             borrow_q, ovf_q, zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                d_q      <= d_d;
                borrow_q <= borrow_d;
                ovf_q    <= ovf_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
